mac_neuron_serial: RTL and testbench
====================================

Name: mac_neuron_serial

Overview:
Time-multiplexed, parametrised neuron. It accepts N_IN activations as a valid/ready stream, one per beat, and multiplies each by a weight held in an internal writable weight memory. It accumulates the products plus a bias, applies ReLU, rescales by an arithmetic right shift and saturates to OUT_W bits. It replaces the fully parallel per-node neurons in the layer generators, so one multiplier serves any fan-in.

Parameters:
N_IN, 15, inputs per neuron (frame length), >=1
DW, 24, activation input width, signed two's complement
WW, 8, weight width, signed
ACC_W, 40, accumulator width, signed; must be >= DW+WW+clog2(N_IN)+1
SHIFT, 5, right shift applied before saturation
OUT_W, 8, output width, unsigned
BIAS, 0, signed bias, ACC_W bits, added once per frame

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  activation beat valid
in_ready  out  1  block can accept a beat
in_data  in  DW  signed activation
w_we  in  1  weight write enable
w_addr  in  clog2(N_IN) (min 1)  weight index
w_data  in  WW  signed weight
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  OUT_W  activated result

Behaviour:
- Reset: synchronous, active-high; clock clk. While reset is high at an edge:
  - state goes to ACC; cnt=0; acc=0.
  - out_valid=0, out_data=0, in_ready=1 after the edge.
  - All weights are cleared to 0.
  - Reset mid-frame discards the partial sum. Reset also drops a pending result.
- States: ACC, ACT, OUT.
- ACC:
  - in_ready=1.
  - A beat is accepted when in_valid&&in_ready at the edge.
  - prod = sign-extended in_data * w_mem[cnt], full DW+WW signed product.
  - acc <= (cnt==0 ? BIAS : acc) + prod, in ACC_W bits, two's-complement wrap.
  - cnt increments on each accepted beat.
  - On the beat with cnt==N_IN-1: cnt<=0 and state<=ACT.
  - in_valid low means no change.
- ACT: in_ready=0. For one cycle, compute and register:
  - acc negative (sign bit set): out_data=0.
  - otherwise s = acc >>> SHIFT. If s > 2^OUT_W-1, out_data = all ones; else out_data = s[OUT_W-1:0].
  - Set out_valid<=1; state<=OUT.
- OUT:
  - in_ready=0; out_valid=1; out_data held stable.
  - When out_ready is high at an edge: out_valid<=0 and state<=ACC.
  - Earliest next beat is accepted the cycle after handoff; no bypass.
- Latency: if the last beat is accepted at edge k, out_valid=1 after edge k+1. Handoff takes at least 1 cycle. Throughput is at most 1 frame per N_IN+2 cycles.
- Weight port:
  - A write takes effect at the edge when w_we is high, in any state.
  - w_addr>=N_IN: write ignored.
  - Write to the index being read in the same cycle: the MAC uses the old weight (read-before-write).
  - Reset overrides a coincident write.
- in_data, w_data and w_addr are don't-care when their qualifier is low.
- in_ready depends only on state, never combinationally on in_valid or out_ready.

Optional Feature:
NEURON_SAT_STATUS_EN:
- When defined, adds two outputs.
  - out_sat (1 bit): registered with out_data; 1 when the result was clipped to all ones. Negative clamp does not count.
  - sat_count (16 bits): counts saturated results at the ACT cycle; sticks at 16'hFFFF; cleared by reset.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- N_IN=4, weights {2,-1,3,1}, inputs {100,50,20,10}, out_ready=1:
  - acc=220, out_data=6.
  - out_valid=1 exactly one cycle after the 4th beat's accepting edge, for one cycle.
- Weights all -1, inputs all 10 -> out_data=0 (ReLU clamp); out_sat=0 when enabled.
- Weights all 127, inputs all 100:
  - acc=50800, s=1587 -> out_data=255.
  - With NEURON_SAT_STATUS_EN: out_sat=1 and sat_count increments by 1; after 65536 such frames it stays at 65535.
- BIAS=64, weights 0, inputs any -> out_data=2. Hold out_ready=0 for 5 cycles: out_data stable, in_ready=0, in_valid pulses ignored. Release: next frame starts cleanly.
- Reset asserted after 2 accepted beats, then a full 4-beat frame of the first scenario (weights rewritten) -> out_data=6, with no leftover partial sum.
- Gaps and write collisions:
  - Run the first scenario with in_valid gaps of 1-3 cycles: same result.
  - Write w_addr=1 to 5 on the edge that accepts beat 1: that frame still uses -1, giving 6. The next identical frame gives (200+250+60+10)>>5=16.

Source files
------------

// File: rtl/mac_neuron_serial.sv
// Serial multiply-accumulate neuron: one multiplier streams a frame of N_IN activations through
// a writable weight memory, then applies bias, ReLU, rescale and saturation. Option: NEURON_SAT_STATUS_EN.
module mac_neuron_serial #(
  parameter int unsigned N_IN  = 15,
  parameter int unsigned DW    = 24,
  parameter int unsigned WW    = 8,
  parameter int unsigned ACC_W = 40,
  parameter int unsigned SHIFT = 5,
  parameter int unsigned OUT_W = 8,
  parameter logic signed [ACC_W-1:0] BIAS = '0,
  localparam int unsigned AW = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DW-1:0]    in_data,
  input  logic                    w_we,
  input  logic [AW-1:0]           w_addr,
  input  logic signed [WW-1:0]    w_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data
`ifdef NEURON_SAT_STATUS_EN
  ,
  output logic                    out_sat,
  output logic [15:0]             sat_count
`endif
);

  localparam int unsigned PW = DW + WW;
  localparam logic [AW-1:0] LAST = AW'(N_IN - 1);
  localparam logic [AW:0] N_IN_L = (AW + 1)'(N_IN);

  typedef enum logic [1:0] {ST_ACC, ST_ACT, ST_OUT} state_e;

  state_e                   state_q, state_d;
  logic [AW-1:0]            cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     out_valid_q, out_valid_d;
  logic [OUT_W-1:0]         out_data_q, out_data_d;
  logic                     in_ready_q, in_ready_d;
  logic signed [WW-1:0]     w_mem_q [N_IN];

  logic signed [WW-1:0]     w_rd_c;
  logic signed [PW-1:0]     prod_c;
  logic signed [ACC_W-1:0]  shifted_c;
  logic                     clip_c;
  logic                     sat_hit_c;
  logic [OUT_W-1:0]         act_c;

`ifdef NEURON_SAT_STATUS_EN
  logic                     out_sat_q, out_sat_d;
  logic [15:0]              sat_count_q, sat_count_d;
`endif

  // Datapath: full-width signed product and the activation of the finished sum
  assign w_rd_c    = w_mem_q[cnt_q];
  assign prod_c    = PW'(in_data) * PW'(w_rd_c);
  assign shifted_c = acc_q >>> SHIFT;
  assign clip_c    = |shifted_c[ACC_W-1:OUT_W];
  assign sat_hit_c = !acc_q[ACC_W-1] && clip_c;
  assign act_c     = acc_q[ACC_W-1] ? '0 : (clip_c ? '1 : shifted_c[OUT_W-1:0]);

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef NEURON_SAT_STATUS_EN
    out_sat_d   = out_sat_q;
    sat_count_d = sat_count_q;
`endif
    unique case (state_q)
      ST_ACC: begin
        if (in_valid && in_ready_q) begin
          acc_d = ((cnt_q == '0) ? BIAS : acc_q) + ACC_W'(prod_c);
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = ST_ACT;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      ST_ACT: begin
        out_data_d  = act_c;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
`ifdef NEURON_SAT_STATUS_EN
        out_sat_d = sat_hit_c;
        if (sat_hit_c && (sat_count_q != 16'hFFFF)) begin
          sat_count_d = sat_count_q + 16'd1;
        end
`endif
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
    in_ready_d = (state_d == ST_ACC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ACC;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
`ifdef NEURON_SAT_STATUS_EN
      out_sat_q   <= 1'b0;
      sat_count_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
`ifdef NEURON_SAT_STATUS_EN
      out_sat_q   <= out_sat_d;
      sat_count_q <= sat_count_d;
`endif
    end
  end

  // Weight memory: reads see the pre-edge value, out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        w_mem_q[i] <= '0;
      end
    end else if (w_we && ({1'b0, w_addr} < N_IN_L)) begin
      w_mem_q[w_addr] <= w_data;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`ifdef NEURON_SAT_STATUS_EN
  assign out_sat   = out_sat_q;
  assign sat_count = sat_count_q;
`endif

endmodule

// File: tb/tb_mac_neuron_serial.sv
// Directed scoreboard bench for mac_neuron_serial: two instances (BIAS 0 and 64) share stimulus.
module tb_mac_neuron_serial;

  localparam int unsigned N_IN  = 4;
  localparam int unsigned DW    = 24;
  localparam int unsigned WW    = 8;
  localparam int unsigned ACC_W = 40;
  localparam int unsigned SHIFT = 5;
  localparam int unsigned OUT_W = 8;
  localparam int unsigned AW    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset, in_valid, w_we, out_ready;
  logic [DW-1:0]        in_data;
  logic [AW-1:0]        w_addr;
  logic [WW-1:0]        w_data;
  logic                 in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [OUT_W-1:0]     out_data_a, out_data_b;
`ifdef NEURON_SAT_STATUS_EN
  logic                 out_sat_a, out_sat_b;
  logic [15:0]          sat_count_a, sat_count_b;
`endif

  mac_neuron_serial #(.N_IN(N_IN), .DW(DW), .WW(WW), .ACC_W(ACC_W), .SHIFT(SHIFT),
                      .OUT_W(OUT_W), .BIAS(40'sd0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a)
`ifdef NEURON_SAT_STATUS_EN
    , .out_sat(out_sat_a), .sat_count(sat_count_a)
`endif
  );

  mac_neuron_serial #(.N_IN(N_IN), .DW(DW), .WW(WW), .ACC_W(ACC_W), .SHIFT(SHIFT),
                      .OUT_W(OUT_W), .BIAS(40'sd64)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b)
`ifdef NEURON_SAT_STATUS_EN
    , .out_sat(out_sat_b), .sat_count(sat_count_b)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   w_model[N_IN];
  int   exp_sat_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] act(input longint acc);
    longint s;
    if (acc < 0) return 8'd0;
    s = acc >>> SHIFT;
    return (s > 255) ? 8'd255 : 8'(s);
  endfunction

  task automatic push_expected(input int d0, input int d1, input int d2, input int d3);
    exp_t   e;
    longint acc;
    acc = longint'(d0) * w_model[0] + longint'(d1) * w_model[1]
        + longint'(d2) * w_model[2] + longint'(d3) * w_model[3];
    e.a   = act(acc);
    e.b   = act(acc + 64);
    e.sat = (acc >= 0) && ((acc >>> SHIFT) > 255);
    if (e.sat) exp_sat_cnt++;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, "_valid"}, 64'(out_valid_a), 64'd1);
    check({tag, "_valid_b"}, 64'(out_valid_b), 64'd1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_data"}, 64'(out_data_a), 64'(e.a));
      check({tag, "_data_b"}, 64'(out_data_b), 64'(e.b));
`ifdef NEURON_SAT_STATUS_EN
      check({tag, "_sat"}, 64'(out_sat_a), 64'(e.sat));
      check({tag, "_satcnt"}, 64'(sat_count_a), 64'(exp_sat_cnt));
`endif
    end
  endtask

  task automatic write_w(input int addr, input int val);
    w_we   = 1'b1;
    w_addr = AW'(addr);
    w_data = WW'(val);
    @(negedge clk);
    w_we = 1'b0;
    w_model[addr] = val;
  endtask

  task automatic write_all(input int v0, input int v1, input int v2, input int v3);
    write_w(0, v0);
    write_w(1, v1);
    write_w(2, v2);
    write_w(3, v3);
  endtask

  // Drives one frame; g>0 inserts 1-3 idle cycles before each beat; col selects the beat
  // whose accepting edge also writes weight 1 to 5.
  task automatic run_frame(input string tag, input int d0, input int d1, input int d2,
                           input int d3, input int g, input int col);
    int d[N_IN];
    d = '{d0, d1, d2, d3};
    push_expected(d0, d1, d2, d3);
    for (int i = 0; i < int'(N_IN); i++) begin
      if (g > 0) begin
        in_valid = 1'b0;
        repeat (1 + ((i + g) % 3)) @(negedge clk);
      end
      check({tag, "_in_ready"}, 64'(in_ready_a), 64'd1);
      in_valid = 1'b1;
      in_data  = DW'(d[i]);
      if (i == col) begin
        w_we   = 1'b1;
        w_addr = AW'(1);
        w_data = WW'(5);
      end
      @(negedge clk);
      w_we = 1'b0;
      if (i == col) w_model[1] = 5;
    end
    in_valid = 1'b0;
    check({tag, "_act_cycle"}, 64'(out_valid_a), 64'd0);
    @(negedge clk);
    pop_check(tag);
    if (out_ready) begin
      @(negedge clk);
      check({tag, "_one_cycle"}, 64'(out_valid_a), 64'd0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    w_we      = 1'b0;
    w_addr    = '0;
    w_data    = '0;
    out_ready = 1'b1;
    for (int i = 0; i < int'(N_IN); i++) w_model[i] = 0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready_a), 64'd1);
    check("rst_out_valid", 64'(out_valid_a), 64'd0);
    check("rst_out_data", 64'(out_data_a), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    write_all(2, -1, 3, 1);
    run_frame("basic", 100, 50, 20, 10, 0, -1);
    run_frame("gaps", 100, 50, 20, 10, 1, -1);
    run_frame("gaps2", 100, 50, 20, 10, 2, -1);
    run_frame("collide", 100, 50, 20, 10, 0, 1);
    run_frame("after_wr", 100, 50, 20, 10, 0, -1);

    write_all(-1, -1, -1, -1);
    run_frame("relu", 10, 10, 10, 10, 0, -1);

    write_all(127, 127, 127, 127);
    run_frame("sat1", 100, 100, 100, 100, 0, -1);
    run_frame("sat2", 100, 100, 100, 100, 0, -1);

    // Bias-only frame with a stalled consumer
    write_all(0, 0, 0, 0);
    out_ready = 1'b0;
    run_frame("bias", 7, 8, 9, 10, 0, -1);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      in_data  = DW'(123);
      @(negedge clk);
      check("hold_valid", 64'(out_valid_b), 64'd1);
      check("hold_data", 64'(out_data_b), 64'd2);
      check("hold_in_ready", 64'(in_ready_b), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_valid", 64'(out_valid_a), 64'd0);
    check("release_in_ready", 64'(in_ready_a), 64'd1);
    write_all(2, -1, 3, 1);
    run_frame("post_hold", 100, 50, 20, 10, 0, -1);

    // Reset with a partial sum in flight
    in_valid = 1'b1;
    in_data  = DW'(100);
    @(negedge clk);
    in_data  = DW'(50);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < int'(N_IN); i++) w_model[i] = 0;
    exp_sat_cnt = 0;
    check("mid_rst_in_ready", 64'(in_ready_a), 64'd1);
    check("mid_rst_out_valid", 64'(out_valid_a), 64'd0);
    check("mid_rst_out_data", 64'(out_data_a), 64'd0);
`ifdef NEURON_SAT_STATUS_EN
    check("mid_rst_satcnt", 64'(sat_count_a), 64'd0);
`endif
    write_all(2, -1, 3, 1);
    run_frame("post_rst", 100, 50, 20, 10, 0, -1);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
